// File: rtl/max_pkg.sv
// Shared types and helpers for the streaming extreme-value reducers.
package max_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Widest sample the masked-key helper supports.
    localparam int unsigned KEY_MAX_W = 64;

    function automatic int unsigned idx_w(input int unsigned frame_len);
        return $clog2(frame_len);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // Clear the lsb low bits so near-equal samples compare as equal.
    function automatic logic [KEY_MAX_W-1:0] mask_key(input logic [KEY_MAX_W-1:0] x,
                                                      input int unsigned         lsb);
        return x & ~((KEY_MAX_W'(1) << lsb) - KEY_MAX_W'(1));
    endfunction

endpackage

// File: rtl/max_cmp_sel.sv
// Combinational strict-better test: take_b when b beats a under the selected extreme.
module max_cmp_sel
    import max_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned SIGNED     = 0,
    parameter int unsigned APPROX_LSB = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode_min,
    output logic         take_b
);

    logic [W-1:0] key_a;
    logic [W-1:0] key_b;
    logic         b_gt;
    logic         b_lt;

    assign key_a = W'(mask_key(KEY_MAX_W'(a), APPROX_LSB));
    assign key_b = W'(mask_key(KEY_MAX_W'(b), APPROX_LSB));

    // Masking low bits leaves the sign bit intact, so signed order is preserved.
    generate
        if (SIGNED != 0) begin : g_signed
            assign b_gt = $signed(key_b) > $signed(key_a);
            assign b_lt = $signed(key_b) < $signed(key_a);
        end else begin : g_unsigned
            assign b_gt = key_b > key_a;
            assign b_lt = key_b < key_a;
        end
    endgenerate

    assign take_b = mode_min ? b_lt : b_gt;

endmodule

// File: rtl/max_stream_reducer.sv
// Frame-wise running max/min over a valid/ready sample stream, reporting value, index and length.
module max_stream_reducer
    import max_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned SIGNED     = 0,
    parameter int unsigned APPROX_LSB = 0,
    localparam int unsigned IDX_W     = idx_w(FRAME_LEN),
    localparam int unsigned CNT_W     = cnt_w(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_min,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_value,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_count
);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     best_val;
    logic [IDX_W-1:0] best_idx;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;

    logic             xfer_in;
    logic             xfer_out;
    logic             first;
    logic             take;
    logic             closing;
    logic [CNT_W-1:0] cnt_nxt;
    logic [W-1:0]     win_val;
    logic [IDX_W-1:0] win_idx;

    max_cmp_sel #(
        .W          (W),
        .SIGNED     (SIGNED),
        .APPROX_LSB (APPROX_LSB)
    ) u_cmp (
        .a        (best_val),
        .b        (in_data),
        .mode_min (mode_q),
        .take_b   (take)
    );

    // Any sample accepted outside ACCUM opens a new frame.
    assign first    = (state != ACCUM);
    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;
    assign cnt_nxt  = first ? CNT_W'(1) : cnt + CNT_W'(1);
    assign closing  = in_last | (cnt_nxt == CNT_W'(FRAME_LEN));
    assign win_val  = (first | take) ? in_data : best_val;
    assign win_idx  = first ? IDX_W'(0) : (take ? IDX_W'(cnt) : best_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (xfer_in) state_nxt = closing ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (xfer_in && closing) state_nxt = HOLD;
            end
            HOLD: begin
                if (xfer_out) begin
                    if (xfer_in) state_nxt = closing ? HOLD : ACCUM;
                    else         state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        in_ready  = (state != HOLD) | out_ready;
        out_valid = (state == HOLD);
    end

    // Best-so-far tracking plus result capture on the closing sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_val  <= '0;
            best_idx  <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            out_value <= '0;
            out_idx   <= '0;
            out_count <= '0;
        end else if (xfer_in) begin
            best_val <= win_val;
            best_idx <= win_idx;
            cnt      <= cnt_nxt;
            if (first) mode_q <= mode_min;
            if (closing) begin
                out_value <= win_val;
                out_idx   <= win_idx;
                out_count <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_max_stream_reducer.sv
// Bench for max_stream_reducer: three configurations (unsigned, signed, approximate) with FRAME_LEN=4.
module tb_max_stream_reducer;

    typedef struct {
        int             dut;
        int             n;
        logic [3:0][7:0] s;
        bit             last;
        bit             mode;
        logic [7:0]     ev;
        int             ei;
        int             ec;
    } vec_t;

    typedef struct {
        logic [7:0] v;
        int         i;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_min  [3];
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [7:0] in_data   [3];
    logic       in_last   [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [7:0] out_value [3];
    logic [1:0] out_idx   [3];
    logic [2:0] out_count [3];

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    vec_t vt[12];

    always #5 clk = ~clk;

    max_stream_reducer #(.W(8), .FRAME_LEN(4), .SIGNED(0), .APPROX_LSB(0)) u_uns (
        .clk(clk), .rst(rst), .mode_min(mode_min[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_value(out_value[0]), .out_idx(out_idx[0]), .out_count(out_count[0]));

    max_stream_reducer #(.W(8), .FRAME_LEN(4), .SIGNED(1), .APPROX_LSB(0)) u_sgn (
        .clk(clk), .rst(rst), .mode_min(mode_min[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_value(out_value[1]), .out_idx(out_idx[1]), .out_count(out_count[1]));

    max_stream_reducer #(.W(8), .FRAME_LEN(4), .SIGNED(0), .APPROX_LSB(2)) u_apx (
        .clk(clk), .rst(rst), .mode_min(mode_min[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_value(out_value[2]), .out_idx(out_idx[2]), .out_count(out_count[2]));

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input int n, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] e, input bit last, input bit mode,
                                input logic [7:0] ev, input int ei, input int ec);
        vec_t v;
        v.dut = d; v.n = n; v.last = last; v.mode = mode;
        v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = e;
        v.ev = ev; v.ei = ei; v.ec = ec;
        return v;
    endfunction

    task automatic push_exp(input int d, input logic [7:0] v, input int i, input int c);
        exp_t e;
        e.v = v; e.i = i; e.c = c;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output exp_t e, output bit ok);
        ok = 1'b0;
        e.v = '0; e.i = 0; e.c = 0;
        case (d)
            0:       if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Scoreboard: each result transfer is checked against the oldest expectation for that instance.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst && out_valid[d] && out_ready[d]) begin
                exp_t e;
                bit   ok;
                pop_exp(d, e, ok);
                if (!ok) begin
                    chk($sformatf("dut%0d unexpected result value", d), int'(out_value[d]), -1);
                end else begin
                    chk($sformatf("dut%0d value", d), int'(out_value[d]), int'(e.v));
                    chk($sformatf("dut%0d idx", d),   int'(out_idx[d]),   e.i);
                    chk($sformatf("dut%0d count", d), int'(out_count[d]), e.c);
                end
            end
        end
    end

    // Offer one sample from just after a rising edge until it is accepted.
    task automatic drive_sample(input int d, input logic [7:0] data, input bit last, input bit mode);
        bit got = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_last[d]  = last;
        mode_min[d] = mode;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk($sformatf("dut%0d in_ready timeout", d), 0, 1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    // Mode is inverted after the first sample so the frame's latched mode is what counts.
    task automatic send_frame(input vec_t v);
        push_exp(v.dut, v.ev, v.ei, v.ec);
        for (int i = 0; i < v.n; i++) begin
            drive_sample(v.dut, v.s[i], v.last && (i == v.n - 1), (i == 0) ? v.mode : ~v.mode);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(0, 4, 8'h03, 8'h09, 8'h02, 8'h09, 0, 0, 8'h09, 1, 4);
        vt[1]  = mk(1, 4, 8'h05, 8'hF0, 8'h7F, 8'h80, 0, 1, 8'h80, 3, 4);
        vt[2]  = mk(0, 2, 8'h04, 8'h07, 8'h00, 8'h00, 1, 0, 8'h07, 1, 2);
        vt[3]  = mk(0, 1, 8'h05, 8'h00, 8'h00, 8'h00, 1, 0, 8'h05, 0, 1);
        vt[4]  = mk(2, 3, 8'h10, 8'h13, 8'h14, 8'h00, 1, 0, 8'h14, 2, 3);
        vt[5]  = mk(2, 2, 8'h10, 8'h13, 8'h00, 8'h00, 1, 0, 8'h10, 0, 2);
        vt[6]  = mk(0, 4, 8'h08, 8'h03, 8'h05, 8'h03, 0, 1, 8'h03, 1, 4);
        vt[7]  = mk(1, 4, 8'h80, 8'h7F, 8'hFF, 8'h00, 0, 0, 8'h7F, 1, 4);
        vt[8]  = mk(2, 4, 8'h23, 8'h20, 8'h21, 8'h1F, 0, 1, 8'h1F, 3, 4);
        vt[9]  = mk(1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 1, 8'hFF, 0, 1);
        vt[10] = mk(0, 4, 8'hC8, 8'h64, 8'h32, 8'h19, 0, 0, 8'hC8, 0, 4);
        vt[11] = mk(1, 3, 8'hFE, 8'hFF, 8'hFE, 8'h00, 1, 0, 8'hFF, 1, 3);

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            mode_min[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0;
            in_last[d] = 1'b0; out_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d reset out_valid", d), int'(out_valid[d]), 0);
            chk($sformatf("dut%0d reset out_value", d), int'(out_value[d]), 0);
            chk($sformatf("dut%0d reset out_idx", d),   int'(out_idx[d]),   0);
            chk($sformatf("dut%0d reset out_count", d), int'(out_count[d]), 0);
            chk($sformatf("dut%0d reset in_ready", d),  int'(in_ready[d]),  1);
        end

        foreach (vt[k]) send_frame(vt[k]);

        // Back-to-back frames on one instance with no idle cycle between them.
        send_frame(mk(0, 2, 8'h11, 8'h22, 8'h00, 8'h00, 1, 0, 8'h22, 1, 2));
        send_frame(mk(0, 4, 8'h40, 8'h30, 8'h40, 8'h50, 0, 0, 8'h50, 3, 4));
        repeat (3) @(posedge clk);
        #1;

        // Result latency and backpressure with a pending sample.
        out_ready[0] = 1'b0;
        push_exp(0, 8'h04, 3, 4);
        drive_sample(0, 8'h01, 0, 0);
        drive_sample(0, 8'h02, 0, 1);
        drive_sample(0, 8'h03, 0, 1);
        chk("latency before close out_valid", int'(out_valid[0]), 0);
        drive_sample(0, 8'h04, 0, 1);
        chk("latency after close out_valid", int'(out_valid[0]), 1);
        in_valid[0] = 1'b1; in_data[0] = 8'h50; in_last[0] = 1'b1; mode_min[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d out_valid", k), int'(out_valid[0]), 1);
            chk($sformatf("stall%0d in_ready", k),  int'(in_ready[0]),  0);
            chk($sformatf("stall%0d out_value", k), int'(out_value[0]), 8'h04);
            chk($sformatf("stall%0d out_idx", k),   int'(out_idx[0]),   3);
        end
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        push_exp(0, 8'h50, 0, 1);
        @(negedge clk);
        chk("release in_ready", int'(in_ready[0]), 1);
        @(posedge clk);
        #1 in_valid[0] = 1'b0; in_last[0] = 1'b0;
        chk("no bubble out_valid", int'(out_valid[0]), 1);
        chk("no bubble out_value", int'(out_value[0]), 8'h50);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame discards the partial frame.
        drive_sample(0, 8'h09, 0, 0);
        drive_sample(0, 8'h08, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midframe reset out_valid", int'(out_valid[0]), 0);
        chk("midframe reset out_value", int'(out_value[0]), 0);
        send_frame(mk(0, 4, 8'h02, 8'h06, 8'h06, 8'h01, 0, 0, 8'h06, 1, 4));
        repeat (2) @(posedge clk);
        #1;

        // Reset in HOLD drops the pending result.
        out_ready[0] = 1'b0;
        drive_sample(0, 8'h33, 1, 0);
        chk("hold before reset out_valid", int'(out_valid[0]), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready[0] = 1'b1;
        chk("hold reset out_valid", int'(out_valid[0]), 0);
        chk("hold reset out_value", int'(out_value[0]), 0);

        for (int k = 0; k < 20; k++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("dut0 pending results", q0.size(), 0);
        chk("dut1 pending results", q1.size(), 0);
        chk("dut2 pending results", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
